fifo_wide2narrow: RTL and testbench

// Width down-converting FIFO, the opposite direction of the 4b->32b flushable FIFO.

---
 rtl/fifo_wide2narrow.sv | 90 +++++++++
 tb/tb_fifo_wide2narrow.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wide2narrow.sv
// Width down-converting FIFO: 32-bit words tagged with a valid-nibble count go in,
// one 4-bit nibble comes out per read; padding nibbles of partial words are skipped.
module fifo_wide2narrow #(
  parameter int depth    = 4,
  parameter int rd_width = 4,
  parameter int wr_width = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [wr_width-1:0] wr_data,
  input  logic [3:0]          wr_nibs,
  input  logic                rd,
  output logic [rd_width-1:0] rd_data,
  output logic                rd_vld,
  output logic                empty,
  output logic                full,
  output logic [5:0]          nib_cnt
);

  localparam int clmn = wr_width / rd_width;
  localparam int aw   = $clog2(depth);
  localparam int cw   = $clog2(clmn);

  // Handshake: a write completes on a clock edge where wr && !full && wr_nibs!=0;
  // a read completes on an edge where rd && rd_vld. rd_data is valid whenever
  // rd_vld is high. Neither side sees the other's same-cycle effect (no bypass).

  logic [wr_width-1:0] mem [depth];
  logic [3:0]          len [depth];
  logic [aw:0]         wr_ptr;
  logic [aw:0]         rd_ptr;
  logic [cw-1:0]       rd_col;
  logic [5:0]          nib_cnt_q;

  logic [3:0]          wr_len;
  logic                wr_acc;
  logic                rd_acc;
  logic                head_last;
  logic [wr_width-1:0] head_word;

  assign wr_len    = (wr_nibs > 4'(clmn)) ? 4'(clmn) : wr_nibs;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr == {~rd_ptr[aw], rd_ptr[aw-1:0]});
  assign rd_vld    = ~empty;
  assign nib_cnt   = nib_cnt_q;
  assign wr_acc    = wr && !full && (wr_nibs != 4'd0);
  assign rd_acc    = rd && !empty;
  assign head_word = mem[rd_ptr[aw-1:0]];
  assign head_last = ({1'b0, rd_col} == (len[rd_ptr[aw-1:0]] - 4'd1));
  assign rd_data   = empty ? '0 : head_word[rd_col*rd_width +: rd_width];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
        len[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (wr_acc) begin
      // One entry per write, even for partial words: entries are never packed.
      mem[wr_ptr[aw-1:0]] <= wr_data;
      len[wr_ptr[aw-1:0]] <= wr_len;
      wr_ptr              <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      rd_col <= '0;
    end else if (rd_acc) begin
      if (head_last) begin
        rd_col <= '0;
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        rd_col <= rd_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nib_cnt_q <= '0;
    end else begin
      nib_cnt_q <= nib_cnt_q + (wr_acc ? {2'b00, wr_len} : 6'd0) - (rd_acc ? 6'd1 : 6'd0);
    end
  end

endmodule

// File: tb/tb_fifo_wide2narrow.sv
// Bench for fifo_wide2narrow: directed steps plus random traffic, checked against
// a nibble-queue reference model of the FIFO's observable behaviour.
module tb_fifo_wide2narrow;

  logic        clk;
  logic        rst;
  logic        wr;
  logic [31:0] wr_data;
  logic [3:0]  wr_nibs;
  logic        rd;
  logic [3:0]  rd_data;
  logic        rd_vld;
  logic        empty;
  logic        full;
  logic [5:0]  nib_cnt;

  int tests;
  int fails;

  // Reference model: every stored nibble in delivery order, plus the count of
  // nibbles still unread in each occupied entry (its size is the entry count).
  logic [3:0] exp_q[$];
  int         ent_q[$];

  fifo_wide2narrow dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .wr_data (wr_data),
    .wr_nibs (wr_nibs),
    .rd      (rd),
    .rd_data (rd_data),
    .rd_vld  (rd_vld),
    .empty   (empty),
    .full    (full),
    .nib_cnt (nib_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic        m_empty;
    logic        m_full;
    logic [3:0]  m_data;
    m_empty = (exp_q.size() == 0);
    m_full  = (ent_q.size() == 4);
    m_data  = m_empty ? 4'h0 : exp_q[0];
    check({ctx, "/empty"},   {31'd0, empty},  {31'd0, m_empty});
    check({ctx, "/rd_vld"},  {31'd0, rd_vld}, {31'd0, ~m_empty});
    check({ctx, "/full"},    {31'd0, full},   {31'd0, m_full});
    check({ctx, "/nib_cnt"}, {26'd0, nib_cnt}, 32'(exp_q.size()));
    check({ctx, "/rd_data"}, {28'd0, rd_data}, {28'd0, m_data});
  endtask

  // driver: apply one cycle of inputs, check pre-edge outputs, clock, update model
  task automatic step(input string ctx, input logic w, input logic [31:0] d,
                      input logic [3:0] n, input logic r);
    bit w_ok;
    bit r_ok;
    int cl;
    wr = w; wr_data = d; wr_nibs = n; rd = r;
    #1;
    check_outputs(ctx);
    w_ok = w && (ent_q.size() < 4) && (n != 0);
    r_ok = r && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (r_ok) begin
      void'(exp_q.pop_front());
      ent_q[0] = ent_q[0] - 1;
      if (ent_q[0] == 0) void'(ent_q.pop_front());
    end
    if (w_ok) begin
      cl = (n > 8) ? 8 : int'(n);
      for (int i = 0; i < cl; i++) exp_q.push_back(d[4*i +: 4]);
      ent_q.push_back(cl);
    end
    wr = 1'b0; rd = 1'b0; wr_nibs = 4'd0;
  endtask

  task automatic do_wr(input string ctx, input logic [31:0] d, input logic [3:0] n);
    step(ctx, 1'b1, d, n, 1'b0);
  endtask

  task automatic do_rd(input string ctx);
    step(ctx, 1'b0, 32'd0, 4'd0, 1'b1);
  endtask

  task automatic drain(input string ctx);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) do_rd(ctx);
    check_outputs({ctx, "/drained"});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    ent_q.delete();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] nibs;
    tests = 0;
    fails = 0;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; wr_data = '0; wr_nibs = '0;
    #2;
    check_outputs("por");
    apply_reset();

    // 1: full word, eight reads
    do_wr("t1_wr", 32'h8765_4321, 4'd8);
    check({"t1_head"}, {28'd0, rd_data}, 32'h1);
    for (int i = 0; i < 8; i++) do_rd("t1_rd");
    check_outputs("t1_end");

    // 2: partial word, padding never shown
    do_wr("t2_wr", 32'h0000_0CBA, 4'd3);
    for (int i = 0; i < 3; i++) do_rd("t2_rd");
    check_outputs("t2_end");
    check("t2_empty", {31'd0, empty}, 32'd1);

    // 3: fill, ignored write, free a slot, write again
    for (int i = 0; i < 4; i++) do_wr("t3_fill", $urandom, 4'd8);
    check("t3_full", {31'd0, full}, 32'd1);
    check("t3_cnt", {26'd0, nib_cnt}, 32'd32);
    do_wr("t3_wr_full", 32'hDEAD_BEEF, 4'd8);
    for (int i = 0; i < 8; i++) do_rd("t3_rd");
    check("t3_notfull", {31'd0, full}, 32'd0);
    do_wr("t3_wr5", 32'hCAFE_F00D, 4'd8);
    drain("t3");

    // 4: simultaneous wr/rd, then wrap through ten entries
    do_wr("t4_wr2", 32'h0000_0021, 4'd2);
    step("t4_both", 1'b1, 32'hFEDC_BA98, 4'd8, 1'b1);
    check("t4_cnt", {26'd0, nib_cnt}, 32'd9);
    for (int i = 0; i < 10; i++) begin
      nibs = 4'($urandom_range(1, 8));
      step("t4_wrap", 1'b1, $urandom, nibs, 1'($urandom_range(0, 1)));
      while (ent_q.size() >= 3) do_rd("t4_wrap_rd");
    end
    drain("t4");

    // 5: zero-length write, oversize count, read when empty
    do_wr("t5_nibs0", 32'h1234_5678, 4'd0);
    check("t5_nibs0_empty", {31'd0, empty}, 32'd1);
    do_wr("t5_nibs15", 32'h1234_5678, 4'd15);
    check("t5_nibs15_cnt", {26'd0, nib_cnt}, 32'd8);
    drain("t5");
    do_rd("t5_rd_empty");
    check("t5_rd_data0", {28'd0, rd_data}, 32'd0);

    // 6: reset mid-operation, first write lands in a clean FIFO
    do_wr("t6_wr_a", $urandom, 4'd8);
    do_wr("t6_wr_b", $urandom, 4'd5);
    for (int i = 0; i < 3; i++) do_rd("t6_rd");
    apply_reset();
    do_wr("t6_post", 32'h0000_0A5C, 4'd4);
    drain("t6");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0));
    end
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
